add_round_key_stage: RTL and testbench
======================================

Name: add_round_key_stage

Overview:
Registered AES AddRoundKey stage placed directly downstream of mixCol128. Consumes each 128-bit column-mixed state, XORs it with the round key for the current round, and presents the result with a valid/ready handshake. The round keys live in a local table loaded by a write port. An internal round counter selects the key and tracks progress through each block.

Parameters:
NR, 10, number of cipher rounds. The key table holds NR+1 entries and rounds run 0..NR.
RW, 4, width of round index and key address; must satisfy 2^RW > NR.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
in_data  in  128  state word from mixCol128, byte 0 in bits [127:120]
in_first  in  1  qualifies in_data as round 0 of a new block
in_valid  in  1  in_data/in_first valid
in_ready  out  1  stage can accept this cycle
out_data  out  128  in_data XOR round key
out_round  out  RW  round index used for out_data
out_last  out  1  out_round == NR
out_valid  out  1  output registers hold a result
out_ready  in  1  downstream accepts output
key_we  in  1  round-key table write enable
key_addr  in  RW  table entry, 0..NR
key_data  in  128  round key
key_err  out  1  one-cycle pulse; meaning depends on the optional feature

Behaviour:
- Reset (rst_n=0 at clock edge):
  - out_data=0, out_round=0, out_last=0, out_valid=0, key_err=0.
  - Round counter rnd=0; all key table entries cleared to 0.
  - Reset overrides any handshake or key write in the same cycle.
  - Reset mid-block abandons the block; the next accepted word is round 0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready.
  - Latency is 1 cycle from accept to out_valid=1 with the result.
  - out_valid stays 1 and output registers are frozen while out_ready=0.
  - Back-to-back accepts give full throughput with out_ready held at 1.
  - If out_valid=1, out_ready=1 and there is no accept, out_valid drops to 0 next cycle.
- Round selection on accept:
  - Used round r = in_first ? 0 : rnd.
  - out_data <= in_data ^ key[r]; out_round <= r; out_last <= (r==NR).
  - rnd update: rnd <= (r==NR) ? 0 : r+1. It wraps after the final round, so a new block may start without in_first.
  - in_first mid-block restarts at round 0.
- Key table:
  - key_we writes key[key_addr] <= key_data at the clock edge.
  - key_addr > NR: write is ignored and key_err pulses.
  - A write and an accept reading the same entry in the same cycle: the XOR uses the old key; the new key applies from the next cycle.
- All XOR is 128-bit bitwise; there is no carry or width growth.

Optional Feature:
ARK_KEY_LOCK_EN
- Defined: key writes are ignored while a block is in flight, i.e. rnd != 0 or an out_valid word has out_last=0. Each rejected write pulses key_err for one cycle. Out-of-range writes also pulse key_err.
- Undefined: writes are always accepted (subject to the address range), so keys may change mid-block. key_err pulses only for key_addr > NR.

Test Plan:
- Reset, load key[0]=000102030405060708090a0b0c0d0e0f, then accept in_data=00112233445566778899aabbccddeeff with in_first=1 -> next cycle out_valid=1, out_data=00102030405060708090a0b0c0d0e0f0, out_round=0, out_last=0.
- Keys 0..10 set to all-0; stream 11 words 000102030405060708090a0b0c0d0e0f with out_ready=1 -> outputs equal the input, out_round 0..10 on consecutive cycles, out_last=1 only on the 11th output, rnd back to 0.
- Hold out_ready=0 with one result pending -> in_ready=0, and out_data stays frozen for 5 cycles. Release -> the queued word is accepted the same cycle and its result appears the next cycle.
- Issue key_we to key[1] in the same cycle as a round-1 accept -> out_data uses the old key[1]; the next round-1 word uses the new key.
- key_we with key_addr=15 -> key_err=1 for exactly one cycle, and all table entries are unchanged.
- Assert rst_n=0 after round 5, then accept a word without in_first -> out_round=0, out_valid=0 during reset. With ARK_KEY_LOCK_EN, a write during round 3 -> key_err pulse and the key is unchanged.

Source files
------------

// File: rtl/add_round_key_stage.sv
// AES AddRoundKey stage: XORs each column-mixed state with the key of its round, from a local key table.
// Latency: 1 cycle from accept to out_valid; back-to-back accepts run at full throughput.
// Backpressure: in_ready = !out_valid || out_ready; the output registers stay frozen while out_ready is low.
// Optional build macro ARK_KEY_LOCK_EN: when defined, key writes are rejected while a block is in flight.
module add_round_key_stage #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [127:0]  in_data,
    input  logic          in_first,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [127:0]  out_data,
    output logic [RW-1:0] out_round,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic          key_we,
    input  logic [RW-1:0] key_addr,
    input  logic [127:0]  key_data,
    output logic          key_err
);

    localparam logic [RW-1:0] LAST_RND = RW'(NR);

    // Round key table, one entry per round 0..NR
    logic [127:0]  key_q [0:NR];

    logic [RW-1:0] rnd_q,       rnd_d;
    logic [127:0]  out_data_q,  out_data_d;
    logic [RW-1:0] out_round_q, out_round_d;
    logic          out_last_q,  out_last_d;
    logic          out_valid_q, out_valid_d;
    logic          key_err_q,   key_err_d;

    logic          accept;
    logic [RW-1:0] use_rnd;
    logic          use_last;
    logic [127:0]  sel_key;
    logic          addr_ok;
    logic          key_lock;
    logic          key_wr_ok;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // in_first forces round 0, which also restarts a block that is mid-way through
    assign use_rnd  = in_first ? '0 : rnd_q;
    assign use_last = (use_rnd == LAST_RND);

    // Select the key of the round in use; reads the table as it stands before this edge
    always_comb begin
        sel_key = '0;
        for (int i = 0; i <= NR; i++) begin
            if (use_rnd == RW'(i)) begin
                sel_key = key_q[i];
            end
        end
    end

`ifdef ARK_KEY_LOCK_EN
    // A block is in flight once round 0 has been taken and until its last round has been issued
    assign key_lock = (rnd_q != '0) || (out_valid_q && !out_last_q);
`else
    assign key_lock = 1'b0;
`endif

    assign addr_ok   = (key_addr <= LAST_RND);
    assign key_wr_ok = key_we && addr_ok && !key_lock;
    assign key_err_d = key_we && !key_wr_ok;

    // Next-state for the output registers and the round counter
    always_comb begin
        out_data_d  = out_data_q;
        out_round_d = out_round_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        rnd_d       = rnd_q;
        if (accept) begin
            out_data_d  = in_data ^ sel_key;
            out_round_d = use_rnd;
            out_last_d  = use_last;
            out_valid_d = 1'b1;
            // Wrap after the final round so the next block may start without in_first
            rnd_d       = use_last ? '0 : use_rnd + RW'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output, round counter and error-pulse registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_round_q <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            rnd_q       <= '0;
            key_err_q   <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_round_q <= out_round_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            rnd_q       <= rnd_d;
            key_err_q   <= key_err_d;
        end
    end

    // Key table writes; reset clears every entry and wins over a same-cycle write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) begin
                key_q[i] <= '0;
            end
        end else if (key_wr_ok) begin
            for (int i = 0; i <= NR; i++) begin
                if (key_addr == RW'(i)) begin
                    key_q[i] <= key_data;
                end
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_round = out_round_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign key_err   = key_err_q;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Bench for add_round_key_stage: table-driven block stream plus hand-written corner sequences.
// Expected results are pushed to a scoreboard queue at accept and popped when the output handshakes.
// Works with or without ARK_KEY_LOCK_EN defined.
module tb_add_round_key_stage;

`ifdef ARK_KEY_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] in_data;
    logic         in_first;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic [3:0]   out_round;
    logic         out_last;
    logic         out_valid;
    logic         out_ready;
    logic         key_we;
    logic [3:0]   key_addr;
    logic [127:0] key_data;
    logic         key_err;

    add_round_key_stage #(.NR(10), .RW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_first  (in_first),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_round (out_round),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .key_we    (key_we),
        .key_addr  (key_addr),
        .key_data  (key_data),
        .key_err   (key_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] d;
        logic [3:0]   r;
        logic         l;
    } exp_t;

    typedef struct {
        logic [127:0] d;
        logic         f;
        logic [127:0] ed;
        logic [3:0]   er;
        logic         el;
    } vec_t;

    exp_t         sb_q [$];
    exp_t         sb_e;
    logic [127:0] mkey [0:10];
    vec_t         tv [12];
    int           total = 0;
    int           bad   = 0;

    localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] D1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] E1  = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] K1A = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    localparam logic [127:0] K1B = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    localparam logic [127:0] K2  = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] KX  = 128'hffffffff_00000000_ffffffff_00000000;
    localparam logic [127:0] PA  = 128'h3243f6a8_885a308d_313198a2_e0370734;
    localparam logic [127:0] PB  = 128'h55aa55aa_0f0f0f0f_f0f0f0f0_12345678;
    localparam logic [127:0] PQ  = 128'h0badc0de_feedface_a5a5a5a5_76543210;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Output side of the scoreboard: the word handshakes at the next rising edge
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra: got %h want no output", out_data);
            end else begin
                sb_e = sb_q.pop_front();
                chk("sb_data", out_data, sb_e.d);
                chk("sb_round", {124'd0, out_round}, {124'd0, sb_e.r});
                chk("sb_last", {127'd0, out_last}, {127'd0, sb_e.l});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        key_we   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i <= 10; i++) mkey[i] = '0;
    endtask

    task automatic wr_key(input logic [3:0] a, input logic [127:0] d, input logic ok);
        key_addr = a;
        key_data = d;
        key_we   = 1'b1;
        tick();
        key_we = 1'b0;
        chk("key_err_wr", {127'd0, key_err}, {127'd0, !ok});
        if (ok) mkey[a] = d;
    endtask

    // Drive one word; expectation is queued only if the stage is ready this cycle
    task automatic send(input logic [127:0] d, input logic f, input logic [127:0] ed,
                        input logic [3:0] er, input logic el);
        in_data  = d;
        in_first = f;
        in_valid = 1'b1;
        #1;
        chk("send_in_ready", {127'd0, in_ready}, 128'd1);
        if (in_ready === 1'b1) sb_q.push_back('{d: ed, r: er, l: el});
        @(posedge clk);
        #1;
        chk("lat_valid", {127'd0, out_valid}, 128'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic run_block(input logic [127:0] p);
        for (int i = 0; i <= 10; i++) begin
            send(p, i == 0, p ^ mkey[i], 4'(i), i == 10);
        end
        idle();
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_first  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        key_we    = 1'b0;
        key_addr  = '0;
        key_data  = '0;

        // Reset state
        do_reset();
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_out_round", {124'd0, out_round}, 128'd0);
        chk("rst_out_last", {127'd0, out_last}, 128'd0);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_key_err", {127'd0, key_err}, 128'd0);
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);

        // Single round-0 word with a known key
        wr_key(4'd0, K0, 1'b1);
        send(D1, 1'b1, E1, 4'd0, 1'b0);
        chk("t1_data", out_data, E1);
        chk("t1_round", {124'd0, out_round}, 128'd0);
        chk("t1_last", {127'd0, out_last}, 128'd0);
        idle();
        tick();
        chk("t1_valid_drop", {127'd0, out_valid}, 128'd0);

        // Full block with zero keys, then one more word without in_first to show the wrap
        do_reset();
        for (int i = 0; i <= 10; i++) wr_key(4'(i), 128'd0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            tv[i].d  = K0;
            tv[i].f  = (i == 0);
            tv[i].ed = K0;
            tv[i].er = (i < 11) ? 4'(i) : 4'd0;
            tv[i].el = (i == 10);
        end
        for (int i = 0; i < 12; i++) begin
            send(tv[i].d, tv[i].f, tv[i].ed, tv[i].er, tv[i].el);
            chk("tv_round", {124'd0, out_round}, {124'd0, tv[i].er});
            chk("tv_last", {127'd0, out_last}, {127'd0, tv[i].el});
        end
        idle();
        tick();

        // Backpressure: one result pending, next word queued, output frozen
        out_ready = 1'b0;
        send(PA, 1'b1, PA, 4'd0, 1'b0);
        in_data  = PB;
        in_first = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
            chk("bp_frozen", out_data, PA);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {127'd0, in_ready}, 128'd1);
        if (in_ready === 1'b1) sb_q.push_back('{d: PB, r: 4'd1, l: 1'b0});
        tick();
        idle();
        chk("bp_next_data", out_data, PB);
        chk("bp_next_round", {124'd0, out_round}, 128'd1);
        tick();

        // Key write colliding with a round-1 accept reading the same entry
        do_reset();
        wr_key(4'd1, K1A, 1'b1);
        send(PA, 1'b1, PA, 4'd0, 1'b0);
        in_data  = PB;
        in_first = 1'b0;
        in_valid = 1'b1;
        key_we   = 1'b1;
        key_addr = 4'd1;
        key_data = K1B;
        #1;
        chk("col_in_ready", {127'd0, in_ready}, 128'd1);
        if (in_ready === 1'b1) sb_q.push_back('{d: PB ^ K1A, r: 4'd1, l: 1'b0});
        tick();
        key_we = 1'b0;
        idle();
        chk("col_old_key", out_data, PB ^ K1A);
        chk("col_key_err", {127'd0, key_err}, {127'd0, LOCK});
        if (!LOCK) mkey[1] = K1B;
        send(PA, 1'b1, PA, 4'd0, 1'b0);
        send(PQ, 1'b0, PQ ^ mkey[1], 4'd1, 1'b0);
        idle();
        tick();

        // Out-of-range key address: one-cycle error pulse, table untouched
        wr_key(4'd15, KX, 1'b0);
        tick();
        chk("oor_err_single", {127'd0, key_err}, 128'd0);
        run_block(PQ);

        // Reset mid-block: same-cycle accept and key write are overridden
        for (int i = 0; i <= 5; i++) send(PA, i == 0, PA ^ mkey[i], 4'(i), 1'b0);
        idle();
        tick();
        rst_n    = 1'b0;
        in_data  = PB;
        in_valid = 1'b1;
        key_we   = 1'b1;
        key_addr = 4'd3;
        key_data = KX;
        tick();
        chk("mrst_valid", {127'd0, out_valid}, 128'd0);
        chk("mrst_round", {124'd0, out_round}, 128'd0);
        chk("mrst_data", out_data, 128'd0);
        rst_n  = 1'b1;
        key_we = 1'b0;
        idle();
        for (int i = 0; i <= 10; i++) mkey[i] = '0;
        send(PQ, 1'b0, PQ, 4'd0, 1'b0);
        chk("mrst_restart_round", {124'd0, out_round}, 128'd0);
        send(PB, 1'b0, PB, 4'd1, 1'b0);
        send(PA, 1'b0, PA, 4'd2, 1'b0);
        send(PA, 1'b0, PA, 4'd3, 1'b0);
        idle();
        tick();

        // Key write during round 3 of a block
        do_reset();
        wr_key(4'd2, K2, 1'b1);
        send(PA, 1'b1, PA, 4'd0, 1'b0);
        send(PA, 1'b0, PA, 4'd1, 1'b0);
        send(PA, 1'b0, PA ^ K2, 4'd2, 1'b0);
        idle();
        wr_key(4'd2, KX, !LOCK);
        tick();
        chk("lock_err_single", {127'd0, key_err}, 128'd0);
        send(PB, 1'b0, PB, 4'd3, 1'b0);
        send(PA, 1'b1, PA, 4'd0, 1'b0);
        send(PA, 1'b0, PA, 4'd1, 1'b0);
        send(PA, 1'b0, PA ^ mkey[2], 4'd2, 1'b0);
        idle();
        tick();
        tick();
        tick();

        chk("sb_drained", 128'(sb_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
